// File: rtl/midi_out_ctrl.sv
// MIDI output controller: CPU output-port writes feed a small byte FIFO that is
// drained as 8N1 UART frames on the MIDI line; status is pollable by the CPU.
module midi_out_ctrl #(
    parameter int unsigned CLK_DIV = 800,
    parameter int unsigned DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [1:0] port_sel,
    input  logic [7:0] wdata,
    output logic       tx,
    output logic [7:0] status
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned BAUD_W = $clog2(CLK_DIV);
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               enable;
    logic               overflow;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    logic baud_last;
    logic push;
    logic ctrl_wr;
    logic pop;
    logic accept;
    logic reject;
    logic fifo_empty;
    logic fifo_full;
    logic tx_busy;
    logic tx_c;

    assign baud_last  = (baud_cnt == BAUD_W'(CLK_DIV - 1));
    assign fifo_empty = (count == CNT_W'(0));
    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign push       = we && (port_sel == 2'd0);
    assign ctrl_wr    = we && (port_sel == 2'd1);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign accept     = push && (!fifo_full || pop);
    assign reject     = push && !accept;

    assign status = {count, overflow, fifo_empty, fifo_full, tx_busy};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (pop) state_nxt = START;
            START: if (baud_last) state_nxt = DATA;
            DATA:  if (baud_last && (bit_idx == 3'd7)) state_nxt = STOP;
            STOP:  if (baud_last) state_nxt = pop ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state line level, busy flag and FIFO pop request
    always_comb begin
        tx_c    = 1'b1;
        tx_busy = 1'b1;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_busy = 1'b0;
                pop     = enable && !fifo_empty;
            end
            START: tx_c = 1'b0;
            DATA:  tx_c = shift[0];
            STOP:  pop  = baud_last && enable && !fifo_empty;
            default: tx_busy = 1'b0;
        endcase
    end

    // FIFO storage; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Datapath: pointers, count, control/overflow flags, baud and bit counters
    always_ff @(posedge clk) begin
        if (reset) begin
            tx       <= 1'b1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            enable   <= 1'b0;
            overflow <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            tx <= tx_c;

            if (ctrl_wr) begin
                enable <= wdata[0];
            end
            // A fresh overflow wins over a clear in the same cycle.
            overflow <= reject || (overflow && !(ctrl_wr && wdata[1]));

            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if ((state == IDLE) || baud_last) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            if ((state == DATA) && baud_last) begin
                bit_idx <= bit_idx + 3'd1;
                shift   <= {1'b0, shift[7:1]};
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                shift  <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_midi_out_ctrl.sv
// Self-checking bench for midi_out_ctrl: directed frame timing plus randomized
// FIFO fill/drain rounds checked against a queue-based reference model.
module tb_midi_out_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned FRAME   = 10 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [1:0] port_sel;
    logic [7:0] wdata;
    logic       tx;
    logic [7:0] status;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    midi_out_ctrl #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .port_sel (port_sel),
        .wdata    (wdata),
        .tx       (tx),
        .status   (status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference status byte from queue occupancy and sticky overflow
    function automatic logic [7:0] exp_status(input int cnt, input bit ov, input bit busy);
        return {4'(cnt), ov, (cnt == 0), (cnt == int'(DEPTH)), busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] p, input logic [7:0] d);
        @(negedge clk);
        we       = 1'b1;
        port_sel = p;
        wdata    = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    // Decode one 8N1 frame by mid-bit sampling; ok=0 if no start bit appears
    task automatic recv_byte(output logic [7:0] b, output int start_cyc,
                             output logic stop_bit, output bit ok);
        ok        = 1'b0;
        b         = '0;
        stop_bit  = 1'b0;
        start_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            start_cyc = cyc;
            repeat (CLK_DIV / 2) step();
            for (int k = 0; k < 8; k++) begin
                repeat (CLK_DIV) step();
                b[k] = tx;
            end
            repeat (CLK_DIV) step();
            stop_bit = tx;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        we       = 1'b0;
        port_sel = 2'd0;
        wdata    = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL reset_tx cycle %0d: got %b expected 1", i, tx);
            end
            checks++;
            if (status !== 8'h04) begin
                errors++;
                $display("FAIL reset_status cycle %0d: got %h expected 04", i, status);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'h90, 1'b0};
        wr(2'd1, 8'h01);
        wr(2'd0, 8'h90);
        step();
        checks++;
        if (tx !== 1'b1 || status !== 8'h05) begin
            errors++;
            $display("FAIL frame_pop: tx %b status %h expected tx 1 status 05", tx, status);
        end
        for (int i = 0; i < int'(FRAME); i++) begin
            step();
            checks++;
            if (tx !== frame[i / int'(CLK_DIV)]) begin
                errors++;
                $display("FAIL frame_bit cycle %0d: got %b expected %b", i, tx,
                         frame[i / int'(CLK_DIV)]);
            end
            if (i < int'(FRAME) - 1) begin
                checks++;
                if (status[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_busy cycle %0d: got %b expected 1", i, status[0]);
                end
            end
        end
        step();
        checks++;
        if (status !== 8'h04 || tx !== 1'b1) begin
            errors++;
            $display("FAIL frame_done: status %h tx %b expected 04 / 1", status, tx);
        end
    endtask

    task automatic test_overflow_zero_gap();
        logic [7:0] data [5];
        logic [7:0] q [$];
        logic [7:0] b;
        logic       stop_bit;
        int         s;
        int         prev_s;
        bit         ok;
        data = '{8'h90, 8'h3C, 8'h7F, 8'h40, 8'h11};
        prev_s = 0;
        wr(2'd1, 8'h00);
        foreach (data[i]) begin
            wr(2'd0, data[i]);
            if (q.size() < int'(DEPTH)) q.push_back(data[i]);
        end
        step();
        checks++;
        if (status !== 8'h4A) begin
            errors++;
            $display("FAIL overflow_status: got %h expected 4a", status);
        end
        wr(2'd1, 8'h01);
        for (int i = 0; i < int'(DEPTH); i++) begin
            recv_byte(b, s, stop_bit, ok);
            checks++;
            if (!ok || b !== q[i] || stop_bit !== 1'b1) begin
                errors++;
                $display("FAIL burst_byte %0d: got %h stop %b ok %0d expected %h stop 1",
                         i, b, stop_bit, ok, q[i]);
            end
            if (i > 0) begin
                checks++;
                if (s - prev_s != int'(FRAME)) begin
                    errors++;
                    $display("FAIL burst_gap %0d: got %0d cycles expected %0d",
                             i, s - prev_s, FRAME);
                end
            end
            prev_s = s;
        end
        repeat (4) step();
        checks++;
        if (status !== 8'h0C) begin
            errors++;
            $display("FAIL burst_final_status: got %h expected 0c", status);
        end
    endtask

    task automatic test_clear_overflow();
        logic [7:0] b;
        logic       stop_bit;
        int         s;
        bit         ok;
        wr(2'd1, 8'h03);
        step();
        checks++;
        if (status !== 8'h04) begin
            errors++;
            $display("FAIL ovf_clear_status: got %h expected 04", status);
        end
        wr(2'd0, 8'hA5);
        recv_byte(b, s, stop_bit, ok);
        checks++;
        if (!ok || b !== 8'hA5 || stop_bit !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear_enable: got %h stop %b ok %0d expected a5", b, stop_bit, ok);
        end
    endtask

    task automatic test_mid_reset();
        bit seen_low;
        bit stayed;
        seen_low = 1'b0;
        wr(2'd0, 8'h5A);
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx === 1'b0) begin
                seen_low = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen_low) begin
            errors++;
            $display("FAIL mid_reset_start: got no start bit expected one");
        end
        repeat (14) step();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1 || status !== 8'h04) begin
            errors++;
            $display("FAIL mid_reset_state: tx %b status %h expected 1 / 04", tx, status);
        end
        stayed = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1) stayed = 1'b0;
        end
        checks++;
        if (!stayed || status !== 8'h04) begin
            errors++;
            $display("FAIL mid_reset_quiet: stayed %0d status %h expected 1 / 04", stayed, status);
        end
    endtask

    task automatic test_disable_mid_frame();
        logic [7:0] b;
        logic [7:0] exp [3];
        logic       stop_bit;
        int         s;
        bit         ok;
        bit         stayed;
        exp = '{8'hC3, 8'h18, 8'hE7};
        wr(2'd1, 8'h00);
        foreach (exp[i]) wr(2'd0, exp[i]);
        wr(2'd1, 8'h01);
        fork
            recv_byte(b, s, stop_bit, ok);
            begin
                repeat (10) step();
                wr(2'd1, 8'h00);
            end
        join
        checks++;
        if (!ok || b !== exp[0] || stop_bit !== 1'b1) begin
            errors++;
            $display("FAIL disable_current: got %h stop %b ok %0d expected %h", b, stop_bit, ok, exp[0]);
        end
        stayed = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1) stayed = 1'b0;
        end
        checks++;
        if (!stayed || status !== exp_status(2, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL disable_hold: stayed %0d status %h expected 1 / %h",
                     stayed, status, exp_status(2, 1'b0, 1'b0));
        end
        wr(2'd1, 8'h01);
        for (int i = 1; i < 3; i++) begin
            recv_byte(b, s, stop_bit, ok);
            checks++;
            if (!ok || b !== exp[i] || stop_bit !== 1'b1) begin
                errors++;
                $display("FAIL disable_resume %0d: got %h stop %b ok %0d expected %h",
                         i, b, stop_bit, ok, exp[i]);
            end
        end
        repeat (4) step();
        checks++;
        if (status !== 8'h04) begin
            errors++;
            $display("FAIL disable_final_status: got %h expected 04", status);
        end
    endtask

    task automatic test_random_rounds();
        logic [7:0] q [$];
        logic [7:0] d;
        logic [7:0] b;
        logic       stop_bit;
        int         k;
        int         s;
        bit         ov;
        bit         ok;
        wr(2'd1, 8'h02);
        for (int r = 0; r < 6; r++) begin
            q.delete();
            ov = 1'b0;
            k  = int'($urandom_range(1, 7));
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 3) == 0) wr(2'($urandom_range(2, 3)), 8'($urandom));
                d = 8'($urandom);
                wr(2'd0, d);
                if (q.size() < int'(DEPTH)) q.push_back(d);
                else ov = 1'b1;
            end
            step();
            checks++;
            if (status !== exp_status(q.size(), ov, 1'b0)) begin
                errors++;
                $display("FAIL rand_fill round %0d: got %h expected %h",
                         r, status, exp_status(q.size(), ov, 1'b0));
            end
            wr(2'd1, 8'h01);
            foreach (q[i]) begin
                recv_byte(b, s, stop_bit, ok);
                checks++;
                if (!ok || b !== q[i] || stop_bit !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_byte round %0d idx %0d: got %h stop %b ok %0d expected %h",
                             r, i, b, stop_bit, ok, q[i]);
                end
            end
            repeat (4) step();
            checks++;
            if (status !== exp_status(0, ov, 1'b0)) begin
                errors++;
                $display("FAIL rand_drain round %0d: got %h expected %h",
                         r, status, exp_status(0, ov, 1'b0));
            end
            wr(2'd1, 8'h02);
            step();
            checks++;
            if (status !== 8'h04) begin
                errors++;
                $display("FAIL rand_clear round %0d: got %h expected 04", r, status);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow_zero_gap();
        test_clear_overflow();
        test_mid_reset();
        test_disable_mid_frame();
        test_random_rounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_out_ctrl.md
Name: midi_out_ctrl

Overview:
- Output-side I/O controller for the monocycle CPU.
- Sits behind the CPU's output-port write path: port strobe, 2-bit port select and 8-bit data.
- Queues MIDI bytes the CPU writes to output port 0 in a small FIFO and serialises them as 8N1 UART frames on the MIDI line.
- Exposes an 8-bit status byte so the CPU can poll it through an input-port mux slot.

Parameters:
- CLK_DIV, 800, clock cycles per serial bit (25 MHz / 31250 baud); must be >= 2.
- DEPTH, 4, FIFO entries; must be a power of two, 2..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- we  input  1  output-port write strobe from CPU; one write per cycle it is high.
- port_sel  input  2  output port number being written.
- wdata  input  8  data written by CPU.
- tx  output  1  MIDI serial line; idle high; registered.
- status  output  8  {count[3:0], overflow, fifo_empty, fifo_full, tx_busy}; combinational from registered state.

Behaviour:
- Port map. Port 0 write: push wdata into FIFO. Port 1 write: control register.
  - bit0 = enable (stored).
  - bit1 = clear overflow (self-clearing, not stored).
  - Writes to ports 2 and 3 are ignored.
- Reset (synchronous, overrides everything, including mid-frame):
  - tx=1, FIFO empty (count=0), enable=0, overflow=0, FSM=IDLE, bit and baud counters=0.
  - status therefore reads 8'b0000_0100 the cycle after reset.
- FIFO:
  - Circular buffer, read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH, 4 bits wide, zero-extended.
  - Push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is discarded and overflow is set (sticky).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Overflow clear and a new overflow in the same cycle: overflow ends set.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, tx_busy=0. If enable=1 and FIFO non-empty, pop head into shift register, go to START. tx falls to 0 on the next edge.
  - START: drive 0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: drive shift[0] for CLK_DIV cycles, shift right, index+1. After index 7 completes, go to STOP. LSB first.
  - STOP: drive 1 for CLK_DIV cycles. Then:
    - if enable=1 and FIFO non-empty, pop and go directly to START (no extra idle bit time);
    - else go to IDLE.
  - tx_busy=1 in START/DATA/STOP.
- Timing:
  - Frame = exactly 10*CLK_DIV cycles.
  - Push at edge N into an empty FIFO with enable=1 and FSM idle: pop at edge N+1, tx low after edge N+2.
  - The baud counter counts 0..CLK_DIV-1 and reloads at each bit boundary.
- Disable (enable cleared) mid-frame: current frame completes normally; no further pops; queued bytes are retained.
- Data is sampled into the shift register at pop. FIFO slot reuse cannot corrupt an in-flight frame.

Test Plan (CLK_DIV=4, DEPTH=4):
- Reset, then idle 20 cycles -> tx=1 constantly, status=8'h04.
- Write port1=8'h01, then port0=8'h90 -> tx: 4 cycles 0, bits 0,0,0,0,1,0,0,1 (4 cycles each), 4 cycles 1; total 40 cycles. tx_busy high throughout the frame. status returns to 8'h04.
- With enable=0, write 8'h90, 8'h3C, 8'h7F, 8'h40, 8'h11 back-to-back:
  - status=8'h4A (count 4, full, overflow); 8'h11 is lost.
  - Then enable=1: four frames 90,3C,7F,40 transmitted with zero gap (160 cycles). Final status=8'h0C.
- Write port1=8'h03 -> overflow cleared, enable still 1, status bit3=0.
- Mid-frame (cycle 15 of a frame) assert reset for 1 cycle -> tx=1 next cycle, status=8'h04, no further frame without a new enable + push.
- Mid-frame write port1=8'h00 with 2 bytes queued -> current frame completes, tx stays 1, count stays 2. Re-enable -> both bytes sent.
